// File: rtl/compute_pkg.sv
// Shared constants for the compute mode dispatcher: FSM state encodings and engine indices.
package compute_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int unsigned MODE_SERIAL   = 0;
  localparam int unsigned MODE_SYSTOLIC = 1;
  localparam int unsigned MODE_CUSTOM   = 2;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag shift register: delays {valid, tag} by RD_LAT cycles to line up with memory read data.
module rd_tag_pipe
  import compute_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_vld,
  input  logic [MODE_W-1:0] push_tag,
  output logic              head_vld,
  output logic [MODE_W-1:0] head_tag
);

  logic [RD_LAT-1:0] vld;
  logic [MODE_W-1:0] tag [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag[i] <= '0;
    end else begin
      vld[0] <= push_vld;
      tag[0] <= push_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
    end
  end

  assign head_vld = vld[RD_LAT-1];
  assign head_tag = tag[RD_LAT-1];

endmodule

// File: rtl/compute_mode_dispatcher.sv
// Arbitrates one single-port memory among NUM_MODES engines with tag-routed read data.
// Optional watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module compute_mode_dispatcher
  import compute_pkg::*;
#(
  parameter  int unsigned NUM_MODES   = 3,
  parameter  int unsigned ADDR_W      = 6,
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned RD_LAT      = 1,
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned MODE_W      = $clog2(NUM_MODES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MODE_W-1:0]           mode_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [NUM_MODES-1:0]        eng_en,
  input  logic [NUM_MODES-1:0]        eng_done,
  input  logic [NUM_MODES*ADDR_W-1:0] eng_addr,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_q,
  output logic [NUM_MODES*DATA_W-1:0] eng_q,
  output logic [NUM_MODES-1:0]        eng_q_vld
);

  localparam int unsigned DRAIN_W = $clog2(RD_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

  logic [1:0]         state;
  logic [MODE_W-1:0]  act;
  logic [ADDR_W-1:0]  act_addr;
  logic [ADDR_W-1:0]  addr_hold;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               act_done;
  logic               mode_ok;
  logic               timeout;
  logic               head_vld;
  logic [MODE_W-1:0]  head_tag;

  assign mode_ok = ({1'b0, mode_sel} < (MODE_W + 1)'(NUM_MODES));

  always_comb begin
    act_addr = '0;
    act_done = 1'b0;
    eng_en   = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (act == MODE_W'(i)) begin
        act_addr  = eng_addr[i*ADDR_W +: ADDR_W];
        act_done  = eng_done[i];
        eng_en[i] = (state == S_RUN);
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                run_cnt <= '0;
    else if (state == S_RUN) run_cnt <= run_cnt + 1'b1;
    else                     run_cnt <= '0;
  end

  assign timeout = (state == S_RUN) && !act_done && (run_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      act       <= '0;
      addr_hold <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && mode_ok) begin
            act   <= mode_sel;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          addr_hold <= act_addr;
          if (act_done || timeout) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= S_FIN;
          else                         drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  // Gated with reset so an illegal start cannot pulse err while reset is held.
  assign err  = rst && (((state == S_IDLE) && start && !mode_ok) || timeout);

  always_comb begin
    mem_addr = '0;
    if (state == S_RUN)        mem_addr = act_addr;
    else if (state == S_DRAIN) mem_addr = addr_hold;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .MODE_W (MODE_W)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_vld (state == S_RUN),
    .push_tag ((state == S_RUN) ? act : '0),
    .head_vld (head_vld),
    .head_tag (head_tag)
  );

  always_comb begin
    eng_q     = '0;
    eng_q_vld = '0;
    for (int unsigned i = 0; i < NUM_MODES; i++) begin
      if (head_vld && (head_tag == MODE_W'(i))) begin
        eng_q[i*DATA_W +: DATA_W] = mem_q;
        eng_q_vld[i]              = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_compute_mode_dispatcher.sv
// Self-checking bench: two dispatchers (RD_LAT=1 and RD_LAT=3) checked against a per-run timeline model.
module tb_compute_mode_dispatcher;

  logic clk;
  logic rst_n;

  logic        start_s     [2];
  logic [1:0]  mode_s      [2];
  logic [2:0]  eng_done_s  [2];
  logic [17:0] eng_addr_s  [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic        err_s       [2];
  logic [2:0]  eng_en_s    [2];
  logic [5:0]  mem_addr_s  [2];
  logic [23:0] eng_q_s     [2];
  logic [2:0]  eng_q_vld_s [2];

  logic [7:0] mem [64];
  logic [7:0] q1, q3a, q3b, q3c;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: 1-cycle and 3-cycle read latency.
  always_ff @(posedge clk) begin
    q1  <= mem[mem_addr_s[0]];
    q3a <= mem[mem_addr_s[1]];
    q3b <= q3a;
    q3c <= q3b;
  end

  compute_mode_dispatcher #(
    .NUM_MODES(3), .ADDR_W(6), .DATA_W(8), .RD_LAT(1), .TIMEOUT_CYC(16)
  ) dut_l1 (
    .clk(clk), .rst(rst_n), .start(start_s[0]), .mode_sel(mode_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .eng_en(eng_en_s[0]),
    .eng_done(eng_done_s[0]), .eng_addr(eng_addr_s[0]), .mem_addr(mem_addr_s[0]),
    .mem_q(q1), .eng_q(eng_q_s[0]), .eng_q_vld(eng_q_vld_s[0])
  );

  compute_mode_dispatcher #(
    .NUM_MODES(3), .ADDR_W(6), .DATA_W(8), .RD_LAT(3), .TIMEOUT_CYC(1024)
  ) dut_l3 (
    .clk(clk), .rst(rst_n), .start(start_s[1]), .mode_sel(mode_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .eng_en(eng_en_s[1]),
    .eng_done(eng_done_s[1]), .eng_addr(eng_addr_s[1]), .mem_addr(mem_addr_s[1]),
    .mem_q(q3c), .eng_q(eng_q_s[1]), .eng_q_vld(eng_q_vld_s[1])
  );

  // One complete run: start cycle (k=0), n RUN cycles, lat DRAIN cycles, FIN.
  // Expected waveform derived from the run plan; noise adds foreign eng_done and starts while busy.
  task automatic do_run(input int d, input int mode, input int n, input int base, input bit noise);
    int          lat;
    logic [5:0]  a [16];
    logic [2:0]  oh;
    logic [2:0]  ev;
    logic [23:0] eq;
    logic [17:0] av;
    logic [5:0]  exp_addr;
    logic [32:0] obs;
    logic [32:0] expv;
    lat = (d == 0) ? 1 : 3;
    oh  = 3'b001 << mode;
    for (int j = 0; j < n; j++) a[j] = (base >= 0) ? 6'(base + j) : 6'($urandom_range(0, 63));
    for (int k = 0; k <= n + lat + 1; k++) begin
      @(negedge clk);
      start_s[d] = (k == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      mode_s[d]  = (k == 0) ? 2'(mode) : (noise ? 2'($urandom_range(0, 3)) : 2'(mode));
      av = 18'($urandom);
      if (k >= 1 && k <= n) av[mode*6 +: 6] = a[k-1];
      eng_addr_s[d] = av;
      eng_done_s[d] = ((k == n) ? oh : 3'b000) | (noise ? ~oh : 3'b000);
      #4;
      ev = 3'b000;
      eq = '0;
      if (k - lat >= 1 && k - lat <= n) begin
        ev = oh;
        eq[mode*8 +: 8] = mem[a[k-lat-1]];
      end
      expv = {(k >= 1), (k == n + lat + 1), 1'b0, ((k >= 1 && k <= n) ? oh : 3'b000), ev, eq};
      obs  = {busy_s[d], done_s[d], err_s[d], eng_en_s[d], eng_q_vld_s[d], eng_q_s[d]};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL run_status d%0d mode%0d cyc%0d: got %h exp %h (busy,done,err,en,vld,q)",
                 d, mode, k, obs, expv);
      end
      if (k <= n + lat) begin
        exp_addr = (k == 0) ? 6'd0 : ((k <= n) ? a[k-1] : a[n-1]);
        checks++;
        if (mem_addr_s[d] !== exp_addr) begin
          errors++;
          $display("FAIL run_mem_addr d%0d mode%0d cyc%0d: got %0d exp %0d",
                   d, mode, k, mem_addr_s[d], exp_addr);
        end
      end
    end
    start_s[d]    = 1'b0;
    eng_done_s[d] = 3'b000;
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    rst_n = 1'b0;
    start_s[0] = 1'b1;
    mode_s[0]  = 2'd3;
    repeat (2) @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      obs = {busy_s[d], done_s[d], err_s[d], eng_en_s[d], mem_addr_s[d], eng_q_vld_s[d], eng_q_s[d]};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs d%0d: got %h exp 0", d, obs);
      end
    end
    start_s[0] = 1'b0;
    mode_s[0]  = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_run(0, 1, 3, 5, 1'b0);
  endtask

  task automatic test_illegal();
    logic [5:0] obs;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      start_s[d] = 1'b1;
      mode_s[d]  = 2'd3;
      #4;
      obs = {busy_s[d], done_s[d], err_s[d], eng_en_s[d]};
      checks++;
      if (obs !== 6'b001000) begin
        errors++;
        $display("FAIL illegal_err d%0d: got %b exp 001000 (busy,done,err,en)", d, obs);
      end
      @(negedge clk);
      start_s[d] = 1'b0;
      mode_s[d]  = 2'd0;
      #4;
      obs = {busy_s[d], done_s[d], err_s[d], eng_en_s[d]};
      checks++;
      if (obs !== 6'b000000) begin
        errors++;
        $display("FAIL illegal_after d%0d: got %b exp 000000 (busy,done,err,en)", d, obs);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_run(1, 0, 2, -1, 1'b0);
    do_run(1, 2, 5, -1, 1'b0);
    do_run(0, 0, 1, -1, 1'b0);
    do_run(0, 2, 2, -1, 1'b0);
  endtask

  task automatic test_foreign_done();
    do_run(0, 2, 4, -1, 1'b1);
    do_run(1, 2, 3, -1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    logic [38:0] obs;
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0]  = 2'd2;
    eng_addr_s[0] = 18'($urandom);
    repeat (3) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      eng_addr_s[0] = 18'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      obs = {busy_s[0], done_s[0], err_s[0], eng_en_s[0], mem_addr_s[0], eng_q_vld_s[0], eng_q_s[0]};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL midrun_reset cyc%0d: got %h exp 0", c, obs);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      obs = {busy_s[0], done_s[0], err_s[0], eng_en_s[0], mem_addr_s[0], eng_q_vld_s[0], eng_q_s[0]};
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL post_reset_idle cyc%0d: got %h exp 0", c, obs);
      end
      @(negedge clk);
    end
    do_run(0, 0, 3, -1, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef DISPATCH_TIMEOUT_EN
    logic [5:0] obs;
    logic [5:0] expv;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      start_s[0]    = (k == 0);
      mode_s[0]     = 2'd1;
      eng_done_s[0] = 3'b000;
      eng_addr_s[0] = 18'($urandom);
      #4;
      expv = {(k == 16), (k == 18), (k >= 1 && k <= 18), ((k >= 1 && k <= 16) ? 3'b010 : 3'b000)};
      obs  = {err_s[0], done_s[0], busy_s[0], eng_en_s[0]};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %b exp %b (err,done,busy,en)", k, obs, expv);
      end
    end
    start_s[0] = 1'b0;
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      do_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(1, 10)), -1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    for (int d = 0; d < 2; d++) begin
      start_s[d]    = 1'b0;
      mode_s[d]     = 2'd0;
      eng_done_s[d] = 3'b000;
      eng_addr_s[d] = '0;
    end
    test_reset();
    test_basic();
    test_illegal();
    test_back_to_back();
    test_foreign_done();
    test_reset_mid_run();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
